// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add multiplier that stalls the pipeline until the low WIDTH product bits are ready.
// Define MUL_SEQUENCER_RADIX4_EN to retire two multiplier bits per cycle (WIDTH must be even).
module mul_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);
`ifdef MUL_SEQUENCER_RADIX4_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int ITERS = WIDTH / STEP;
    localparam int CW = $clog2(ITERS + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;
    logic [WIDTH-1:0] mcand, mplier, acc, addend, acc_next;
    logic [CW-1:0] count;
    logic accept, last;
    always_comb begin
`ifdef MUL_SEQUENCER_RADIX4_EN
        addend = (mplier[0] ? mcand : '0) + (mplier[1] ? {mcand[WIDTH-2:0], 1'b0} : '0);
`else
        addend = mplier[0] ? mcand : '0;
`endif
        acc_next = acc + addend;
        accept = (state == IDLE) & start & ~flush;
        last = count == CW'(ITERS - 1);
        state_next = flush ? IDLE :
                     accept ? RUN :
                     (state == RUN && last) ? DONE :
                     (state == DONE) ? IDLE : state;
        stall = ~reset & ((state == RUN) | accept);
        done = ~reset & (state == DONE);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mcand <= '0;
            mplier <= '0;
            acc <= '0;
            count <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                mcand <= a;
                mplier <= b;
                acc <= '0;
                count <= '0;
            end else if (state == RUN) begin
                acc <= acc_next;
                mcand <= mcand << STEP;
                mplier <= mplier >> STEP;
                count <= count + CW'(1);
                // a flush on the final iteration must leave the previous result intact
                if (last && !flush) result <= acc_next;
            end
        end
    end
endmodule
